// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the multi-cycle RV32I controller.
// Holds opcode constants, ALU op / FSM state / instruction-class enums,
// register write-data select encodings and the opcode classifier.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned RD_SEL_W = 2;
  localparam int unsigned WAIT_W   = 32;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [RD_SEL_W-1:0] RD_SEL_LINK = 2'd0;
  localparam logic [RD_SEL_W-1:0] RD_SEL_ALU  = 2'd1;
  localparam logic [RD_SEL_W-1:0] RD_SEL_ZERO = 2'd2;
  localparam logic [RD_SEL_W-1:0] RD_SEL_MEM  = 2'd3;

  typedef enum logic [3:0] {
    C_RTYPE, C_IALU, C_LUI, C_AUIPC, C_LOAD,
    C_STORE, C_BRANCH, C_JAL, C_JALR, C_ILLEGAL
  } instr_class_t;

  // Map an opcode to its instruction class; anything unknown is illegal.
  function automatic instr_class_t classify(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE:  return C_RTYPE;
      OP_IALU:   return C_IALU;
      OP_LUI:    return C_LUI;
      OP_AUIPC:  return C_AUIPC;
      OP_LOAD:   return C_LOAD;
      OP_STORE:  return C_STORE;
      OP_BRANCH: return C_BRANCH;
      OP_JAL:    return C_JAL;
      OP_JALR:   return C_JALR;
      default:   return C_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational opcode/funct3/funct7[5] to ALU operation.
// Ports: opcode, funct3, funct7_b5 in; alu_op out.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7_b5,
  output alu_op_t             alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE, OP_IALU: begin
        case (funct3)
          // funct7[5] selects SUB only for register-register forms
          3'd0: alu_op = (opcode == OP_RTYPE && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'd1: alu_op = ALU_SLL;
          3'd2: alu_op = ALU_SLT;
          3'd3: alu_op = ALU_SLTU;
          3'd4: alu_op = ALU_XOR;
          3'd5: alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'd6: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OP_LUI: alu_op = ALU_PASSB;
      OP_BRANCH: begin
        case (funct3[2:1])
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: alu_op = ALU_SUB;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEM/WB sequencer driving all
// datapath strobes and mux selects for an RV32I multi-cycle datapath.
// Inputs: clk, reset (async active-low), opcode/funct3/funct7, zero,
//   last_bit, mem_ready. Outputs: ir_en, pc_en, pc_alu_sel, pc_next_sel,
//   alu_a_sel, alu_b_sel, alu_control, reg_we, reg_data_sel, mem_re, mem_we,
//   illegal, state. Outputs are combinational from state and decoded fields.
// Parameter MEM_TIMEOUT: max mem_ready wait cycles (0 = wait forever).
// Macro CPU_ILLEGAL_TRAP_EN: illegal opcode / memory timeout halt the core
//   with a sticky illegal flag; otherwise illegal opcodes retire as NOPs.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                zero,
  input  logic                last_bit,
  input  logic                mem_ready,
  output logic                ir_en,
  output logic                pc_en,
  output logic                pc_alu_sel,
  output logic                pc_next_sel,
  output logic                alu_a_sel,
  output logic                alu_b_sel,
  output logic [ALU_OP_W-1:0] alu_control,
  output logic                reg_we,
  output logic [RD_SEL_W-1:0] reg_data_sel,
  output logic                mem_re,
  output logic                mem_we,
  output logic                illegal,
  output logic [STATE_W-1:0]  state
);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  instr_class_t       cls_c;
  alu_op_t            dec_alu_op_c;
  logic               taken_c;
  logic               mem_timeout_c;
  logic               unused_c;

  assign cls_c    = classify(opcode);
  assign unused_c = ^{funct7[6], funct7[4:0]};

  alu_decoder u_alu_decoder (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_b5 (funct7[5]),
    .alu_op    (dec_alu_op_c)
  );

  // funct3[2] picks the less-than test over equality; funct3[0] inverts it
  assign taken_c = (funct3[2] ? last_bit : zero) ^ funct3[0];

  assign mem_timeout_c = (WAIT_W'(MEM_TIMEOUT) != '0) && !mem_ready &&
                         (wait_cnt_q + WAIT_W'(1) >= WAIT_W'(MEM_TIMEOUT));

  // State and wait-counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef CPU_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky trap flag, set on entry to HALT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal_d = illegal_q | (state_q != S_HALT && state_d == S_HALT);
  assign illegal   = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (cls_c == C_ILLEGAL) begin
`ifdef CPU_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (cls_c)
          C_LOAD, C_STORE:        state_d = S_MEM;
          C_BRANCH, C_JAL, C_JALR: state_d = S_FETCH;
          default:                state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (cls_c == C_LOAD) ? S_WB : S_FETCH;
        end else if (mem_timeout_c) begin
`ifdef CPU_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode; everything is forced low while reset is held
  always_comb begin
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_alu_sel   = 1'b0;
    pc_next_sel  = 1'b0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    alu_control  = ALU_OP_W'(ALU_ADD);
    reg_we       = 1'b0;
    reg_data_sel = RD_SEL_LINK;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    if (reset) begin
      // ALU operands stay stable from EXECUTE through WB
      if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB) begin
        alu_a_sel   = (cls_c == C_AUIPC);
        alu_b_sel   = (cls_c == C_IALU) || (cls_c == C_LUI) || (cls_c == C_AUIPC) ||
                      (cls_c == C_LOAD) || (cls_c == C_STORE) || (cls_c == C_JALR);
        alu_control = dec_alu_op_c;
      end
      case (state_q)
        S_FETCH: ir_en = 1'b1;
        S_DECODE: begin
`ifndef CPU_ILLEGAL_TRAP_EN
          if (cls_c == C_ILLEGAL) begin
            pc_en      = 1'b1;
            pc_alu_sel = 1'b1;
          end
`endif
        end
        S_EXECUTE: begin
          case (cls_c)
            C_BRANCH: begin
              pc_en      = 1'b1;
              pc_alu_sel = !taken_c;
            end
            C_JAL: begin
              reg_we = 1'b1;
              pc_en  = 1'b1;
            end
            C_JALR: begin
              reg_we      = 1'b1;
              pc_en       = 1'b1;
              pc_next_sel = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (cls_c == C_LOAD) begin
            mem_re = 1'b1;
          end else begin
            mem_we = 1'b1;
            if (mem_ready) begin
              pc_en      = 1'b1;
              pc_alu_sel = 1'b1;
            end
          end
        end
        S_WB: begin
          reg_we       = 1'b1;
          reg_data_sel = (cls_c == C_LOAD) ? RD_SEL_MEM : RD_SEL_ALU;
          pc_en        = 1'b1;
          pc_alu_sel   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each cycle the stimulus pushes
// the hand-computed expected outputs (with a care mask); the monitor pops and
// compares on the falling edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic       ir_en;
    logic       pc_en;
    logic       pc_alu_sel;
    logic       pc_next_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [3:0] alu_control;
    logic       reg_we;
    logic [1:0] reg_data_sel;
    logic       mem_re;
    logic       mem_we;
    logic       illegal;
    logic [2:0] state;
  } out_t;

  typedef struct {
    out_t  e;
    out_t  m;
    string nm;
  } exp_t;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LUI_OP = 7'b0110111;
  localparam logic [6:0] AUI_OP = 7'b0010111;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] JLR_OP = 7'b1100111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, last_bit, mem_ready;
  logic       ir_en, pc_en, pc_alu_sel, pc_next_sel, alu_a_sel, alu_b_sel;
  logic [3:0] alu_control;
  logic       reg_we;
  logic [1:0] reg_data_sel;
  logic       mem_re, mem_we, illegal;
  logic [2:0] state;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  out_t act;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .zero         (zero),
    .last_bit     (last_bit),
    .mem_ready    (mem_ready),
    .ir_en        (ir_en),
    .pc_en        (pc_en),
    .pc_alu_sel   (pc_alu_sel),
    .pc_next_sel  (pc_next_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_control  (alu_control),
    .reg_we       (reg_we),
    .reg_data_sel (reg_data_sel),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .illegal      (illegal),
    .state        (state)
  );

  assign act = {ir_en, pc_en, pc_alu_sel, pc_next_sel, alu_a_sel, alu_b_sel,
                alu_control, reg_we, reg_data_sel, mem_re, mem_we, illegal, state};

  // Monitor: one expectation per cycle, compared on the falling edge
  always @(negedge clk) begin : mon
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      total++;
      if (((act ^ x.e) & x.m) != '0) begin
        bad++;
        $display("FAIL %s: got %h required %h (mask %h) state got %0d want %0d",
                 x.nm, act, x.e, x.m, act.state, x.e.state);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic out_t base(input logic [2:0] st);
    out_t r = '0;
    r.state = st;
    return r;
  endfunction

  function automatic out_t bmask();
    out_t r = '0;
    r.ir_en = 1'b1; r.pc_en = 1'b1; r.reg_we = 1'b1;
    r.mem_re = 1'b1; r.mem_we = 1'b1; r.illegal = 1'b1; r.state = 3'b111;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input out_t e, input out_t m);
    exp_t x;
    x.e = e; x.m = m; x.nm = nm;
    sb_q.push_back(x);
  endtask

  // FETCH and DECODE cycles of a legal instruction
  task automatic fd(input string nm, input logic [6:0] op, input logic [2:0] f3,
                    input logic [6:0] f7);
    out_t e;
    opcode = op; funct3 = f3; funct7 = f7;
    e = base(3'd0); e.ir_en = 1'b1;
    chk({nm, "_fetch"}, e, bmask());
    tick();
    chk({nm, "_decode"}, base(3'd1), bmask());
    tick();
  endtask

  task automatic alu_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic a, input logic b,
                           input logic [3:0] ctl);
    out_t e, m;
    fd(nm, op, f3, f7);
    e = base(3'd2); e.alu_a_sel = a; e.alu_b_sel = b; e.alu_control = ctl;
    m = bmask(); m.alu_a_sel = 1'b1; m.alu_b_sel = 1'b1; m.alu_control = 4'hF;
    chk({nm, "_exec"}, e, m);
    tick();
    e = base(3'd4); e.reg_we = 1'b1; e.reg_data_sel = 2'd1; e.pc_en = 1'b1; e.pc_alu_sel = 1'b1;
    m = bmask(); m.reg_data_sel = 2'b11; m.pc_alu_sel = 1'b1; m.pc_next_sel = 1'b1;
    chk({nm, "_wb"}, e, m);
    tick();
  endtask

  task automatic branch(input string nm, input logic [2:0] f3, input logic z,
                        input logic lb, input logic [3:0] ctl, input logic sel);
    out_t e, m;
    zero = z; last_bit = lb;
    fd(nm, BR_OP, f3, 7'd0);
    e = base(3'd2); e.pc_en = 1'b1; e.pc_alu_sel = sel; e.alu_control = ctl;
    m = bmask(); m.pc_alu_sel = 1'b1; m.pc_next_sel = 1'b1; m.alu_control = 4'hF;
    chk({nm, "_exec"}, e, m);
    tick();
  endtask

  initial begin
    out_t e, m;
    reset = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    zero = 1'b0; last_bit = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    m = '1;
    chk("reset_hold", base(3'd0), m);
    tick();
    reset = 1'b1;

    alu_instr("add",   R_OP,   3'd0, 7'h00, 1'b0, 1'b0, 4'd0);
    alu_instr("sub",   R_OP,   3'd0, 7'h20, 1'b0, 1'b0, 4'd1);
    alu_instr("addi7", I_OP,   3'd0, 7'h20, 1'b0, 1'b1, 4'd0);
    alu_instr("srai",  I_OP,   3'd5, 7'h20, 1'b0, 1'b1, 4'd7);
    alu_instr("sltu",  R_OP,   3'd3, 7'h00, 1'b0, 1'b0, 4'd4);
    alu_instr("lui",   LUI_OP, 3'd0, 7'h00, 1'b0, 1'b1, 4'd10);
    alu_instr("auipc", AUI_OP, 3'd0, 7'h00, 1'b1, 1'b1, 4'd0);

    branch("bne_z1",  3'b001, 1'b1, 1'b0, 4'd1, 1'b1);
    branch("bne_z0",  3'b001, 1'b0, 1'b0, 4'd1, 1'b0);
    branch("beq_z1",  3'b000, 1'b1, 1'b0, 4'd1, 1'b0);
    branch("bge_lt",  3'b101, 1'b0, 1'b1, 4'd3, 1'b1);
    branch("bltu_lt", 3'b110, 1'b0, 1'b1, 4'd4, 1'b0);

    // JAL
    fd("jal", JAL_OP, 3'd0, 7'd0);
    e = base(3'd2); e.reg_we = 1'b1; e.pc_en = 1'b1;
    m = bmask(); m.reg_data_sel = 2'b11; m.pc_alu_sel = 1'b1; m.pc_next_sel = 1'b1;
    chk("jal_exec", e, m);
    tick();

    // JALR
    fd("jalr", JLR_OP, 3'd0, 7'd0);
    e = base(3'd2); e.reg_we = 1'b1; e.pc_en = 1'b1; e.pc_next_sel = 1'b1;
    e.alu_b_sel = 1'b1; e.alu_control = 4'd0;
    m = bmask(); m.reg_data_sel = 2'b11; m.pc_next_sel = 1'b1; m.alu_a_sel = 1'b1;
    m.alu_b_sel = 1'b1; m.alu_control = 4'hF;
    chk("jalr_exec", e, m);
    tick();

    // LOAD with three wait cycles
    fd("lw", LD_OP, 3'b010, 7'd0);
    mem_ready = 1'b0;
    e = base(3'd2); e.alu_b_sel = 1'b1;
    m = bmask(); m.alu_b_sel = 1'b1; m.alu_control = 4'hF;
    chk("lw_exec", e, m);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      e = base(3'd3); e.mem_re = 1'b1; e.alu_b_sel = 1'b1;
      chk($sformatf("lw_mem%0d", i), e, m);
      tick();
    end
    e = base(3'd4); e.reg_we = 1'b1; e.reg_data_sel = 2'd3; e.pc_en = 1'b1; e.pc_alu_sel = 1'b1;
    m = bmask(); m.reg_data_sel = 2'b11; m.pc_alu_sel = 1'b1; m.pc_next_sel = 1'b1;
    chk("lw_wb", e, m);
    tick();

    // STORE with mem_ready already high
    fd("sw", ST_OP, 3'b010, 7'd0);
    e = base(3'd2); e.alu_b_sel = 1'b1;
    m = bmask(); m.alu_b_sel = 1'b1; m.alu_control = 4'hF;
    chk("sw_exec", e, m);
    tick();
    e = base(3'd3); e.mem_we = 1'b1; e.pc_en = 1'b1; e.pc_alu_sel = 1'b1; e.alu_b_sel = 1'b1;
    m.pc_alu_sel = 1'b1; m.pc_next_sel = 1'b1;
    chk("sw_mem", e, m);
    tick();

    // Reset asserted while a load waits in MEM
    fd("lw_rst", LD_OP, 3'b010, 7'd0);
    mem_ready = 1'b0;
    chk("lw_rst_exec", base(3'd2), bmask());
    tick();
    e = base(3'd3); e.mem_re = 1'b1;
    chk("lw_rst_mem", e, bmask());
    tick();
    reset = 1'b0;
    m = '1;
    chk("mid_mem_reset", base(3'd0), m);
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    alu_instr("post_rst", R_OP, 3'd0, 7'h00, 1'b0, 1'b0, 4'd0);

    // Illegal opcode
    opcode = 7'b1111111; funct3 = '0; funct7 = '0;
    e = base(3'd0); e.ir_en = 1'b1;
    chk("ill_fetch", e, bmask());
    tick();
`ifdef CPU_ILLEGAL_TRAP_EN
    chk("ill_decode", base(3'd1), bmask());
    tick();
    for (int i = 0; i < 10; i++) begin
      e = base(3'd5); e.illegal = 1'b1;
      chk($sformatf("ill_halt%0d", i), e, bmask());
      tick();
    end
`else
    e = base(3'd1); e.pc_en = 1'b1; e.pc_alu_sel = 1'b1;
    m = bmask(); m.pc_alu_sel = 1'b1; m.pc_next_sel = 1'b1;
    chk("ill_nop", e, m);
    tick();
    e = base(3'd0); e.ir_en = 1'b1;
    chk("ill_refetch", e, bmask());
    tick();
`endif

    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
